// File: rtl/game_pkg.sv
// Shared game constants and the hit/stop FSM state encoding, used by the
// hit-stop controller and by the scroll and spawn blocks.
package game_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STOP   = 2'd1,
    ST_INVULN = 2'd2,
    ST_OVER   = 2'd3
  } hs_state_t;

  localparam int DEF_LIVES         = 3;
  localparam int DEF_STOP_FRAMES   = 30;
  localparam int DEF_INVULN_FRAMES = 90;
  localparam int DEF_BLINK_DIV     = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hit_stop_ctrl_if.sv
// Signal bundle between the game driver (collision/frame logic) and the
// hit-stop controller; state_dbg exposes the FSM state for observation.
interface hit_stop_ctrl_if #(
  parameter int LW = 2
);
  import game_pkg::*;

  // No backpressure anywhere: tick/hit/restart are sampled on every rising clk
  // edge (tick and restart are one-cycle strobes, hit is a level), and all
  // outputs are registered and valid every cycle.
  logic          tick;
  logic          hit;
  logic          restart;
  logic          freeze;
  logic          visible;
  logic [LW-1:0] lives;
  logic          game_over;
  logic          hit_pulse;
  hs_state_t     state_dbg;

  modport master (
    output tick, hit, restart,
    input  freeze, visible, lives, game_over, hit_pulse, state_dbg
  );

  modport slave (
    input  tick, hit, restart,
    output freeze, visible, lives, game_over, hit_pulse, state_dbg
  );

endinterface

// File: rtl/tick_down_counter.sv
// Loadable down counter that steps once per frame tick and parks at zero.
module tick_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;

  // Load beats tick; a tick at zero holds so the counter never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (tick && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/hit_stop_ctrl.sv
// Turns the collision level into lives, a frozen hit-stop, a blinking
// invulnerability window and a latched game-over.
module hit_stop_ctrl
  import game_pkg::*;
#(
  parameter int LIVES         = DEF_LIVES,
  parameter int STOP_FRAMES   = DEF_STOP_FRAMES,
  parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
  parameter int BLINK_DIV     = DEF_BLINK_DIV
) (
  input  logic            clk,
  input  logic            rst_n,
  hit_stop_ctrl_if.slave  bus
);

  localparam int LW      = $clog2(LIVES + 1);
  localparam int CNT_MAX = max_int(STOP_FRAMES, INVULN_FRAMES);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BLK_W   = $clog2(BLINK_DIV + 1);

  localparam logic [CNT_W-1:0] STOP_LOAD   = CNT_W'(STOP_FRAMES - 1);
  localparam logic [CNT_W-1:0] INVULN_LOAD = CNT_W'(INVULN_FRAMES - 1);
  localparam logic [BLK_W-1:0] BLINK_LOAD  = BLK_W'(BLINK_DIV - 1);

  hs_state_t      state_q, state_d;
  logic [LW-1:0]  lives_q, lives_d;
  logic           visible_q, visible_d;
  logic           hit_pulse_q, hit_pulse_d;
  logic           freeze_q, freeze_d;
  logic           game_over_q, game_over_d;

  logic             main_load, main_tick, main_zero;
  logic [CNT_W-1:0] main_val, main_cnt;
  logic             blink_load, blink_tick, blink_zero;
  logic [BLK_W-1:0] blink_val, blink_cnt;
  logic             unused_cnt;

  // Frame ticks only count while frozen or invulnerable; RUN and OVER ignore them.
  assign main_tick  = bus.tick && ((state_q == ST_STOP) || (state_q == ST_INVULN));
  assign blink_tick = bus.tick && (state_q == ST_INVULN);
  assign unused_cnt = ^{main_cnt, blink_cnt};

  tick_down_counter #(.WIDTH(CNT_W)) u_main_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (main_load),
    .load_val (main_val),
    .tick     (main_tick),
    .count    (main_cnt),
    .zero     (main_zero)
  );

  tick_down_counter #(.WIDTH(BLK_W)) u_blink_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (blink_load),
    .load_val (blink_val),
    .tick     (blink_tick),
    .count    (blink_cnt),
    .zero     (blink_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      lives_q     <= LW'(LIVES);
      visible_q   <= 1'b1;
      hit_pulse_q <= 1'b0;
      freeze_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      visible_q   <= visible_d;
      hit_pulse_q <= hit_pulse_d;
      freeze_q    <= freeze_d;
      game_over_q <= game_over_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    visible_d   = visible_q;
    hit_pulse_d = 1'b0;
    main_load   = 1'b0;
    main_val    = '0;
    blink_load  = 1'b0;
    blink_val   = '0;

    if (bus.restart) begin
      state_d    = ST_RUN;
      lives_d    = LW'(LIVES);
      visible_d  = 1'b1;
      main_load  = 1'b1;
      blink_load = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          visible_d = 1'b1;
          if (bus.hit) begin
            hit_pulse_d = 1'b1;
            if (lives_q <= LW'(1)) begin
              lives_d = '0;
              state_d = ST_OVER;
            end else begin
              lives_d   = lives_q - LW'(1);
              state_d   = ST_STOP;
              main_load = 1'b1;
              main_val  = STOP_LOAD;
            end
          end
        end
        ST_STOP: begin
          if (bus.tick && main_zero) begin
            state_d    = ST_INVULN;
            main_load  = 1'b1;
            main_val   = INVULN_LOAD;
            blink_load = 1'b1;
            blink_val  = BLINK_LOAD;
            visible_d  = 1'b0;
          end
        end
        ST_INVULN: begin
          if (bus.tick && main_zero) begin
            state_d    = ST_RUN;
            visible_d  = 1'b1;
            blink_load = 1'b1;
          end else if (bus.tick && blink_zero) begin
            visible_d  = ~visible_q;
            blink_load = 1'b1;
            blink_val  = BLINK_LOAD;
          end
        end
        default: begin
          visible_d = 1'b1;
        end
      endcase
    end

    freeze_d    = (state_d == ST_STOP) || (state_d == ST_OVER);
    game_over_d = (state_d == ST_OVER);
  end

  assign bus.freeze    = freeze_q;
  assign bus.visible   = visible_q;
  assign bus.lives     = lives_q;
  assign bus.game_over = game_over_q;
  assign bus.hit_pulse = hit_pulse_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_hit_stop_ctrl.sv
// Bench for hit_stop_ctrl: directed scenarios plus random hits/restarts,
// checked every cycle against a phase/elapsed-ticks model of the game rules.
module tb_hit_stop_ctrl;
  import game_pkg::*;

  localparam int LIVES         = 3;
  localparam int STOP_FRAMES   = 4;
  localparam int INVULN_FRAMES = 6;
  localparam int BLINK_DIV     = 2;
  localparam int LW            = $clog2(LIVES + 1);

  localparam int M_RUN = 0, M_STOP = 1, M_INV = 2, M_OVER = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  hit_stop_ctrl_if #(.LW(LW)) bus ();

  hit_stop_ctrl #(
    .LIVES         (LIVES),
    .STOP_FRAMES   (STOP_FRAMES),
    .INVULN_FRAMES (INVULN_FRAMES),
    .BLINK_DIV     (BLINK_DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp     = 0;
  int n_bad     = 0;
  int tcnt      = 0;
  int pulse_cnt = 0;

  // Model: game phase, lives left, and ticks elapsed within the current phase.
  int m_mode    = M_RUN;
  int m_lives   = LIVES;
  int m_elapsed = 0;
  bit m_pulse   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin : model
    int nm, nl, ne;
    bit np;
    if (!rst_n) begin
      m_mode    <= M_RUN;
      m_lives   <= LIVES;
      m_elapsed <= 0;
      m_pulse   <= 1'b0;
    end else begin
      nm = m_mode; nl = m_lives; ne = m_elapsed; np = 1'b0;
      if (bus.restart) begin
        nm = M_RUN; nl = LIVES; ne = 0;
      end else begin
        case (m_mode)
          M_RUN: if (bus.hit) begin
            np = 1'b1;
            nl = m_lives - 1;
            nm = (nl == 0) ? M_OVER : M_STOP;
            ne = 0;
          end
          M_STOP: if (bus.tick) begin
            ne = m_elapsed + 1;
            if (ne == STOP_FRAMES) begin nm = M_INV; ne = 0; end
          end
          M_INV: if (bus.tick) begin
            ne = m_elapsed + 1;
            if (ne == INVULN_FRAMES) begin nm = M_RUN; ne = 0; end
          end
          default: ;
        endcase
      end
      m_mode <= nm; m_lives <= nl; m_elapsed <= ne; m_pulse <= np;
    end
  end

  function automatic bit exp_visible();
    if (m_mode != M_INV) return 1'b1;
    return ((m_elapsed / BLINK_DIV) % 2) == 1;
  endfunction

  always @(negedge clk) begin
    chk("freeze", bus.freeze, (m_mode == M_STOP) || (m_mode == M_OVER));
    chk("visible", bus.visible, exp_visible());
    chk("lives", bus.lives, m_lives);
    chk("game_over", bus.game_over, m_mode == M_OVER);
    chk("hit_pulse", bus.hit_pulse, m_pulse);
    if (bus.hit_pulse === 1'b1) pulse_cnt++;
  end

  task automatic drive_cycle(input bit h, input bit r);
    @(negedge clk);
    #1;
    bus.tick    = (tcnt == 4);
    tcnt        = (tcnt + 1) % 5;
    bus.hit     = h;
    bus.restart = r;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_lives"}, bus.lives, 3);
    chk({tag, "_freeze"}, bus.freeze, 0);
    chk({tag, "_visible"}, bus.visible, 1);
    chk({tag, "_game_over"}, bus.game_over, 0);
    chk({tag, "_hit_pulse"}, bus.hit_pulse, 0);
  endtask

  // One hit from RUN, then measure the frozen tick count and blink pattern.
  task automatic single_hit(input string tag, input bit align, input int exp_lives);
    int p0, stop_ticks, nvis, guard;
    logic [5:0] pat;
    p0 = pulse_cnt; stop_ticks = 0; nvis = 0; guard = 0; pat = '0;
    if (align) begin
      while (tcnt != 4) drive_cycle(0, 0);
    end
    drive_cycle(1, 0);
    if (align) chk({tag, "_tick_with_hit"}, bus.tick, 1);
    while (nvis < 6 && guard < 300) begin
      drive_cycle(0, 0);
      guard++;
      if (bus.tick) begin
        if (bus.freeze) stop_ticks++;
        else if (stop_ticks > 0) begin pat[nvis] = bus.visible; nvis++; end
      end
    end
    chk({tag, "_timeout"}, (nvis < 6), 0);
    chk({tag, "_stop_ticks"}, stop_ticks, 4);
    chk({tag, "_blink_pat"}, pat, 6'b001100);
    chk({tag, "_pulses"}, pulse_cnt - p0, 1);
    drive_cycle(0, 0);
    chk({tag, "_lives"}, bus.lives, exp_lives);
    chk({tag, "_run_freeze"}, bus.freeze, 0);
    chk({tag, "_run_visible"}, bus.visible, 1);
  endtask

  initial begin
    int p0, guard;
    bit hcur;
    bus.tick = 1'b0; bus.hit = 1'b0; bus.restart = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive_cycle(0, 0);
    check_reset_vals("reset");

    single_hit("single", 1'b0, 2);

    p0 = pulse_cnt;
    drive_cycle(1, 1);
    drive_cycle(0, 0);
    chk("rst_hit_lives", bus.lives, 3);
    chk("rst_hit_pulse", pulse_cnt - p0, 0);
    chk("rst_hit_freeze", bus.freeze, 0);

    single_hit("hit_tick", 1'b1, 2);

    drive_cycle(0, 1);
    p0 = pulse_cnt;
    repeat (200) drive_cycle(1, 0);
    drive_cycle(0, 0);
    chk("held_pulses", pulse_cnt - p0, 3);
    chk("held_lives", bus.lives, 0);
    chk("held_game_over", bus.game_over, 1);
    chk("held_freeze", bus.freeze, 1);

    drive_cycle(0, 1);
    drive_cycle(0, 0);
    chk("restart_lives", bus.lives, 3);
    chk("restart_game_over", bus.game_over, 0);
    chk("restart_freeze", bus.freeze, 0);

    hcur = 1'b0;
    repeat (1500) begin
      if ($urandom_range(0, 19) == 0) hcur = ~hcur;
      drive_cycle(hcur, $urandom_range(0, 299) == 0);
    end

    drive_cycle(0, 1);
    drive_cycle(1, 0);
    guard = 0;
    drive_cycle(0, 0);
    while (bus.freeze && guard < 100) begin drive_cycle(0, 0); guard++; end
    chk("inv_reach_timeout", (guard >= 100), 0);
    repeat (7) drive_cycle(0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    bus.hit = 1'b0; bus.tick = 1'b0; bus.restart = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    drive_cycle(0, 0);
    check_reset_vals("post_rst");
    single_hit("after_rst", 1'b0, 2);

    repeat (3) drive_cycle(0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    n_bad++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
